base_res_trk: RTL and testbench

//  Consumer-side partner of the tag resource manager. Joins each incoming request with a

---
 rtl/base_res_trk.sv | 133 +++++++++++++
 tb/tb_base_res_trk.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/base_res_trk.sv
// base_res_trk: consumer-side tag tracker. Joins requests with free tags, records
// issued tags as outstanding, validates completion tags and returns them on a
// registered free port. Optional outstanding-bitmap checking is enabled by
// defining BASE_RES_TRK_CHK_EN; without it every accepted completion is forwarded.
module base_res_trk #(
    parameter int width   = 4,
    parameter int num_res = 2**width,
    parameter int dwidth  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    a_v,
    output logic                    a_r,
    input  logic [width-1:0]        a_d,
    input  logic                    r_v,
    output logic                    r_r,
    input  logic [dwidth-1:0]       r_d,
    output logic                    q_v,
    input  logic                    q_r,
    output logic [width+dwidth-1:0] q_d,
    input  logic                    c_v,
    output logic                    c_r,
    input  logic [width-1:0]        c_d,
    output logic                    f_v,
    input  logic                    f_r,
    output logic [width-1:0]        f_d,
    output logic [width:0]          o_cnt,
    output logic                    o_idle,
    output logic                    o_err
);

    localparam logic [width:0] NUM_RES = (width+1)'(num_res);
    localparam logic [width:0] CNT_ONE = (width+1)'(1);

    logic             r_f_v;
    logic [width-1:0] r_f_d;
    logic [width:0]   r_cnt;
    logic             r_err;

    logic w_issue;
    logic w_comp;
    logic w_fwd;
    logic w_inc;
    logic w_dec;
    logic w_err;

    // Issue path is a pure join of request and free tag; no register stage.
    assign q_v = r_v & a_v;
    assign q_d = {a_d, r_d};
    assign r_r = a_v & q_r;
    assign a_r = r_v & q_r;

    // A completion can be taken whenever the free register is empty or draining.
    assign c_r     = ~r_f_v | f_r;
    assign w_issue = r_v & a_v & q_r;
    assign w_comp  = c_v & c_r;

`ifdef BASE_RES_TRK_CHK_EN
    logic [num_res-1:0] r_bitmap;
    logic [num_res-1:0] w_set;
    logic [num_res-1:0] w_clr;
    logic               w_c_in_rng;
    logic               w_a_in_rng;
    logic               w_c_known;
    logic               w_same_tag;
    logic               w_a_busy;

    assign w_c_in_rng = ({1'b0, c_d} < NUM_RES);
    assign w_a_in_rng = ({1'b0, a_d} < NUM_RES);
    assign w_c_known  = w_c_in_rng & r_bitmap[c_d];
    assign w_fwd      = w_comp & w_c_known;
    // A tag freed and re-issued on the same edge is a clean reuse, not a fault.
    assign w_same_tag = w_fwd & (c_d == a_d);
    assign w_a_busy   = ~w_a_in_rng | (r_bitmap[a_d] & ~w_same_tag);
    assign w_inc      = w_issue & ~w_a_busy;
    assign w_dec      = w_fwd;
    assign w_err      = (w_comp & ~w_c_known) | (w_issue & w_a_busy);

    // Per-tag set/clear decode; set wins so a same-edge free+reissue stays outstanding.
    for (genvar gi = 0; gi < num_res; gi++) begin : g_dec
        assign w_set[gi] = w_issue & w_a_in_rng & (a_d == width'(gi));
        assign w_clr[gi] = w_fwd & (c_d == width'(gi));
    end

    // Outstanding bitmap update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_bitmap <= '0;
        else        r_bitmap <= (r_bitmap & ~w_clr) | w_set;
    end
`else
    assign w_fwd = w_comp;
    assign w_inc = w_issue;
    assign w_dec = w_comp;
    assign w_err = 1'b0;
`endif

    // Outstanding count: net of issues and frees, clamped to 0..num_res.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_inc && !w_dec) begin
            if (r_cnt != NUM_RES) r_cnt <= r_cnt + CNT_ONE;
        end else if (w_dec && !w_inc) begin
            if (r_cnt != '0) r_cnt <= r_cnt - CNT_ONE;
        end
    end

    // Free-port register: load on accepted completion, drain on f_r.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_f_v <= 1'b0;
            r_f_d <= '0;
        end else if (w_comp) begin
            r_f_v <= w_fwd;
            if (w_fwd) r_f_d <= c_d;
        end else if (f_r) begin
            r_f_v <= 1'b0;
        end
    end

    // Single-cycle error pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_err <= 1'b0;
        else        r_err <= w_err;
    end

    assign f_v    = r_f_v;
    assign f_d    = r_f_d;
    assign o_cnt  = r_cnt;
    assign o_err  = r_err;
    assign o_idle = (r_cnt == '0) & ~r_f_v;

endmodule

// File: tb/tb_base_res_trk.sv
// Testbench for base_res_trk: directed scenarios plus randomized traffic
// checked against a tag-set reference model. Follows BASE_RES_TRK_CHK_EN.
module tb_base_res_trk;

    logic        clk;
    logic        reset;
    logic        a_v, a_r;
    logic [3:0]  a_d;
    logic        r_v, r_r;
    logic [7:0]  r_d;
    logic        q_v, q_r;
    logic [11:0] q_d;
    logic        c_v, c_r;
    logic [3:0]  c_d;
    logic        f_v, f_r;
    logic [3:0]  f_d;
    logic [4:0]  o_cnt;
    logic        o_idle, o_err;

    int checks = 0;
    int passes = 0;

    // reference model state
    logic [15:0] m_out;
    int          m_cnt;
    logic        m_f_v;
    logic [3:0]  m_f_d;
    logic        m_err;

`ifdef BASE_RES_TRK_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    base_res_trk #(.width(4), .num_res(16), .dwidth(8)) dut (
        .clk(clk), .reset(reset),
        .a_v(a_v), .a_r(a_r), .a_d(a_d),
        .r_v(r_v), .r_r(r_r), .r_d(r_d),
        .q_v(q_v), .q_r(q_r), .q_d(q_d),
        .c_v(c_v), .c_r(c_r), .c_d(c_d),
        .f_v(f_v), .f_r(f_r), .f_d(f_d),
        .o_cnt(o_cnt), .o_idle(o_idle), .o_err(o_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle_inputs();
        a_v = 0; a_d = 0; r_v = 0; r_d = 0; q_r = 0;
        c_v = 0; c_d = 0; f_r = 1;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 0;
        @(negedge clk);
        reset = 1;
        tick();
    endtask

    task automatic issue_tag(input logic [3:0] t);
        a_v = 1; a_d = t; r_v = 1; r_d = 8'($urandom); q_r = 1;
        tick();
        a_v = 0; r_v = 0; q_r = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0;
        a_v = 1; a_d = 4'd3; r_v = 1; r_d = 8'hA5; q_r = 1;
        #12;
        checks++; if (o_cnt !== 5'd0) $display("FAIL reset_cnt got %0d want 0", o_cnt); else passes++;
        checks++; if (f_v !== 1'b0 || f_d !== 4'd0) $display("FAIL reset_f got v=%b d=%0d want v=0 d=0", f_v, f_d); else passes++;
        checks++; if (o_err !== 1'b0 || o_idle !== 1'b1) $display("FAIL reset_flags got err=%b idle=%b want 0/1", o_err, o_idle); else passes++;
        reset = 1;
        #1;
        checks++; if (q_v !== 1'b1 || q_d !== 12'h3A5) $display("FAIL issue_q got v=%b d=%h want 1/3a5", q_v, q_d); else passes++;
        checks++; if (a_r !== 1'b1 || r_r !== 1'b1) $display("FAIL issue_rdy got a_r=%b r_r=%b want 1/1", a_r, r_r); else passes++;
        @(posedge clk); #1;
        a_v = 0; r_v = 0; q_r = 0;
        checks++; if (o_cnt !== 5'd1) $display("FAIL issue_cnt got %0d want 1", o_cnt); else passes++;
        $display("test_reset done");
    endtask

    task automatic test_complete();
        c_v = 1; c_d = 4'd3; f_r = 1;
        #1;
        checks++; if (c_r !== 1'b1) $display("FAIL comp_cr got %b want 1", c_r); else passes++;
        tick();
        c_v = 0;
        checks++; if (f_v !== 1'b1 || f_d !== 4'd3) $display("FAIL comp_f got v=%b d=%0d want 1/3", f_v, f_d); else passes++;
        checks++; if (o_cnt !== 5'd0 || o_idle !== 1'b0) $display("FAIL comp_cnt got cnt=%0d idle=%b want 0/0", o_cnt, o_idle); else passes++;
        tick();
        checks++; if (f_v !== 1'b0 || o_idle !== 1'b1) $display("FAIL comp_idle got f_v=%b idle=%b want 0/1", f_v, o_idle); else passes++;
        $display("test_complete done");
    endtask

    task automatic test_double_free();
        c_v = 1; c_d = 4'd3; f_r = 1;
        tick();
        c_v = 0;
        checks++; if (f_v !== !CHK) $display("FAIL dfree_fv got %b want %b", f_v, !CHK); else passes++;
        checks++; if (o_err !== CHK) $display("FAIL dfree_err got %b want %b", o_err, CHK); else passes++;
        if (!CHK) begin
            checks++; if (f_d !== 4'd3) $display("FAIL dfree_fd got %0d want 3", f_d); else passes++;
        end
        checks++; if (o_cnt !== 5'd0) $display("FAIL dfree_cnt got %0d want 0", o_cnt); else passes++;
        tick();
        checks++; if (o_err !== 1'b0) $display("FAIL dfree_pulse got %b want 0", o_err); else passes++;
        $display("test_double_free done");
    endtask

    task automatic test_backpressure();
        issue_tag(4'd5);
        issue_tag(4'd6);
        checks++; if (o_cnt !== 5'd2) $display("FAIL bp_cnt2 got %0d want 2", o_cnt); else passes++;
        f_r = 0; c_v = 1; c_d = 4'd5;
        tick();
        c_d = 4'd6;
        checks++; if (f_v !== 1'b1 || f_d !== 4'd5) $display("FAIL bp_f5 got v=%b d=%0d want 1/5", f_v, f_d); else passes++;
        checks++; if (c_r !== 1'b0) $display("FAIL bp_cr got %b want 0", c_r); else passes++;
        tick();
        checks++; if (f_v !== 1'b1 || f_d !== 4'd5) $display("FAIL bp_hold got v=%b d=%0d want 1/5", f_v, f_d); else passes++;
        f_r = 1;
        #1;
        checks++; if (c_r !== 1'b1) $display("FAIL bp_cr_rel got %b want 1", c_r); else passes++;
        tick();
        c_v = 0;
        checks++; if (f_v !== 1'b1 || f_d !== 4'd6) $display("FAIL bp_f6 got v=%b d=%0d want 1/6", f_v, f_d); else passes++;
        tick();
        checks++; if (f_v !== 1'b0 || o_cnt !== 5'd0) $display("FAIL bp_drain got v=%b cnt=%0d want 0/0", f_v, o_cnt); else passes++;
        $display("test_backpressure done");
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) issue_tag(4'(i));
        checks++; if (o_cnt !== 5'd16) $display("FAIL full_cnt got %0d want 16", o_cnt); else passes++;
        a_v = 1; a_d = 4'd2; r_v = 1; q_r = 1; c_v = 1; c_d = 4'd7; f_r = 1;
        tick();
        a_v = 0; r_v = 0; q_r = 0; c_v = 0;
        checks++; if (o_cnt !== (CHK ? 5'd15 : 5'd16)) $display("FAIL full_swap_cnt got %0d want %0d", o_cnt, CHK ? 15 : 16); else passes++;
        checks++; if (f_v !== 1'b1 || f_d !== 4'd7) $display("FAIL full_swap_f got v=%b d=%0d want 1/7", f_v, f_d); else passes++;
        checks++; if (o_err !== CHK) $display("FAIL full_swap_err got %b want %b", o_err, CHK); else passes++;
        $display("test_full done");
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 10; i++) issue_tag(4'(i));
        f_r = 0; c_v = 1; c_d = 4'd0;
        tick();
        c_v = 0;
        tick();
        checks++; if (f_v !== 1'b1 || o_cnt !== 5'd9) $display("FAIL arst_pre got v=%b cnt=%0d want 1/9", f_v, o_cnt); else passes++;
        #2;
        reset = 0;
        #1;
        checks++; if (f_v !== 1'b0 || o_cnt !== 5'd0 || o_err !== 1'b0) $display("FAIL arst_now got v=%b cnt=%0d err=%b want 0/0/0", f_v, o_cnt, o_err); else passes++;
        checks++; if (o_idle !== 1'b1) $display("FAIL arst_idle got %b want 1", o_idle); else passes++;
        $display("test_async_reset done");
    endtask

    // reference model: one clock edge of the tag-set rules
    task automatic model_step();
        logic issue, comp, known, err;
        issue = r_v & a_v & q_r;
        comp  = c_v & (~m_f_v | f_r);
        err   = 1'b0;
        if (CHK) begin
            known = comp & m_out[c_d];
            err   = comp & ~known;
            if (known) m_out[c_d] = 1'b0;
            if (issue) begin
                if (m_out[a_d]) err = 1'b1;
                m_out[a_d] = 1'b1;
            end
            m_cnt = $countones(m_out);
        end else begin
            known = comp;
            if (issue && !comp)      m_cnt = (m_cnt == 16) ? 16 : m_cnt + 1;
            else if (comp && !issue) m_cnt = (m_cnt == 0) ? 0 : m_cnt - 1;
            if (comp)  m_out[c_d] = 1'b0;
            if (issue) m_out[a_d] = 1'b1;
        end
        if (comp) begin
            m_f_v = known;
            if (known) m_f_d = c_d;
        end else if (f_r) begin
            m_f_v = 1'b0;
        end
        m_err = err;
    endtask

    function automatic logic [3:0] pick_tag(input logic want_set);
        logic [3:0] t;
        t = 4'($urandom);
        for (int k = 0; k < 16; k++) begin
            if (m_out[t] == want_set) return t;
            t = t + 4'd1;
        end
        return t;
    endfunction

    task automatic test_random();
        int errs;
        errs = 0;
        reset = 1;
        @(negedge clk);
        tick();
        m_out = '0; m_cnt = 0; m_f_v = 0; m_f_d = 0; m_err = 0;
        for (int i = 0; i < 500; i++) begin
            a_v = ($urandom_range(0, 3) != 0);
            a_d = ($urandom_range(0, 7) != 0) ? pick_tag(1'b0) : 4'($urandom);
            r_v = ($urandom_range(0, 2) != 0);
            r_d = 8'($urandom);
            q_r = ($urandom_range(0, 3) != 0);
            c_v = ($urandom_range(0, 1) != 0);
            c_d = ($urandom_range(0, 5) != 0) ? pick_tag(1'b1) : 4'($urandom);
            f_r = ($urandom_range(0, 3) != 0);
            #1;
            checks++; if (q_v !== (r_v & a_v) || q_d !== {a_d, r_d}) begin errs++; $display("FAIL rnd_q cyc %0d got v=%b d=%h want v=%b d=%h", i, q_v, q_d, r_v & a_v, {a_d, r_d}); end else passes++;
            checks++; if (a_r !== (r_v & q_r) || r_r !== (a_v & q_r) || c_r !== (~m_f_v | f_r)) begin errs++; $display("FAIL rnd_rdy cyc %0d got a_r=%b r_r=%b c_r=%b", i, a_r, r_r, c_r); end else passes++;
            checks++; if (o_cnt !== 5'(m_cnt)) begin errs++; $display("FAIL rnd_cnt cyc %0d got %0d want %0d", i, o_cnt, m_cnt); end else passes++;
            checks++; if (f_v !== m_f_v || f_d !== m_f_d) begin errs++; $display("FAIL rnd_f cyc %0d got v=%b d=%0d want v=%b d=%0d", i, f_v, f_d, m_f_v, m_f_d); end else passes++;
            checks++; if (o_err !== m_err || o_idle !== (m_cnt == 0 && !m_f_v)) begin errs++; $display("FAIL rnd_flags cyc %0d got err=%b idle=%b want err=%b", i, o_err, o_idle, m_err); end else passes++;
            model_step();
            @(posedge clk); #1;
        end
        idle_inputs();
        $display("test_random done, %0d mismatching cycles", errs);
    endtask

    initial begin
        idle_inputs();
        reset = 0;
        test_reset();
        test_complete();
        test_double_free();
        test_backpressure();
        test_full();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
